// File: rtl/da2_multi_serializer.sv
// da2_multi_serializer: N-channel DAC121S101 (PmodDA2) serial driver.
// Shared SCLK/SYNC, one SDATA per channel, 16-bit {00,mode,data} frames.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   update     one-cycle request to start a frame
//   value      CHANNELS*DATA_W packed samples (channel k at k*DATA_W)
//   mode       CHANNELS*2 power-down modes (00 normal .. 11 high-Z)
//   busy       frame in progress (33*CLK_DIV cycles per frame)
//   done       pulse on the last busy cycle of each frame
//   dropped    pulse one cycle after an update is lost
//   SCLK       serial clock, idles high
//   SYNC       frame sync, active low
//   SDATA      serial data per channel, MSB first
//
// Build option DA2_PENDING_EN: one-deep pending buffer so an update
// arriving while busy queues the next frame instead of being dropped.
module da2_multi_serializer #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic [CHANNELS*DATA_W-1:0] value,
  input  logic [CHANNELS*2-1:0]      mode,
  output logic                       busy,
  output logic                       done,
  output logic                       dropped,
  output logic                       SCLK,
  output logic                       SYNC,
  output logic [CHANNELS-1:0]        SDATA
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIV_W-1:0]           div_q;
  logic                       phase_q;
  logic [3:0]                 bit_q;
  logic [CHANNELS-1:0][15:0]  sreg_q;
  logic [CHANNELS-1:0][15:0]  frame;
  logic [CHANNELS-1:0][11:0]  samp;
  logic [CHANNELS*DATA_W-1:0] src_value;
  logic [CHANNELS*2-1:0]      src_mode;

  logic div_end;
  logic last_bit;
  logic load;
  logic reload;
  logic drop_d;

`ifdef DA2_PENDING_EN
  logic                       pend_q;
  logic [CHANNELS*DATA_W-1:0] pend_value_q;
  logic [CHANNELS*2-1:0]      pend_mode_q;
  logic                       from_pend;

  // A live update at the HOLD exit is newer than the pending
  // entry, so it wins and the pending entry counts as dropped.
  always_comb begin
    reload    = pend_q | update;
    from_pend = pend_q & ~update;
    drop_d    = update & busy & pend_q;
    src_value = from_pend ? pend_value_q : value;
    src_mode  = from_pend ? pend_mode_q : mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_value_q <= '0;
      pend_mode_q  <= '0;
    end else if (load) begin
      pend_q <= 1'b0;
    end else if (update && busy) begin
      pend_q       <= 1'b1;
      pend_value_q <= value;
      pend_mode_q  <= mode;
    end
  end
`else
  always_comb begin
    reload    = 1'b0;
    drop_d    = update & busy;
    src_value = value;
    src_mode  = mode;
  end
`endif

  assign busy     = (state_q != IDLE);
  assign div_end  = (div_q == DIV_LAST);
  assign last_bit = phase_q && (bit_q == 4'd15);
  assign done     = (state_q == HOLD) && div_end;

  // Samples are MSB-aligned into the 12-bit DAC field.
  always_comb begin
    samp  = '0;
    frame = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      samp[k][11 -: DATA_W] = src_value[k*DATA_W +: DATA_W];
      frame[k] = {2'b00, src_mode[2*k +: 2], samp[k]};
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (update) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (div_end && last_bit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (div_end) begin
          if (reload) begin
            state_d = SHIFT;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dropped <= 1'b0;
    end else begin
      dropped <= drop_d;
    end
  end

  // phase_q=0 is the SCLK-high half of a bit, 1 the low half.
  // Data only moves when the low half ends (SCLK rising).
  always_ff @(posedge clk) begin
    if (rst) begin
      SCLK    <= 1'b1;
      SYNC    <= 1'b1;
      SDATA   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      sreg_q  <= '0;
    end else if (load) begin
      sreg_q  <= frame;
      SYNC    <= 1'b0;
      SCLK    <= 1'b1;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        SDATA[k] <= frame[k][15];
      end
    end else if (state_q != IDLE) begin
      if (!div_end) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        if (state_q == SHIFT) begin
          if (!phase_q) begin
            SCLK    <= 1'b0;
            phase_q <= 1'b1;
          end else begin
            SCLK    <= 1'b1;
            phase_q <= 1'b0;
            if (bit_q == 4'd15) begin
              SYNC  <= 1'b1;
              SDATA <= '0;
            end else begin
              bit_q <= bit_q + 4'd1;
              for (int k = 0; k < CHANNELS; k++) begin
                sreg_q[k] <= {sreg_q[k][14:0], 1'b0};
                SDATA[k]  <= sreg_q[k][14];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_da2_multi_serializer.sv
// tb_da2_multi_serializer: directed bench for da2_multi_serializer.
// Instance A: 2ch/12b/div 2. Instance B: 1ch/8b/div 1.
module tb_da2_multi_serializer;

  localparam int C_SYNC  = 0;
  localparam int C_BUSY  = 1;
  localparam int C_DONE  = 2;
  localparam int C_DROP  = 3;
  localparam int C_FALL  = 4;
  localparam int C_SLOW  = 5;
  localparam int C_BFALL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_update = 1'b0;
  logic [23:0] a_value  = '0;
  logic [3:0]  a_mode   = '0;
  logic        a_busy, a_done, a_dropped, a_sclk, a_sync;
  logic [1:0]  a_sdata;

  logic        b_update = 1'b0;
  logic [7:0]  b_value  = '0;
  logic [1:0]  b_mode   = '0;
  logic        b_busy, b_done, b_dropped, b_sclk, b_sync;
  logic [0:0]  b_sdata;

  int n_cmp = 0;
  int n_err = 0;

  int a_cnt[7];
  int a_base[7];
  int b_cnt[7];
  int b_base[7];
  logic [15:0] a_bits0, a_bits1, b_bits;
  logic a_psclk = 1'b1, a_psync = 1'b1, a_pbusy = 1'b0;
  logic b_psclk = 1'b1, b_psync = 1'b1, b_pbusy = 1'b0;
  int a_cyc = 0, a_done_cyc = 0, a_sync_start = 0;

  logic [7:0]  bv[3];
  logic [1:0]  bm[3];
  logic [15:0] bf[3];

  always #5 clk = ~clk;

  da2_multi_serializer #(
    .CHANNELS(2), .DATA_W(12), .CLK_DIV(2)
  ) u_a (
    .clk(clk), .rst(rst), .update(a_update),
    .value(a_value), .mode(a_mode),
    .busy(a_busy), .done(a_done), .dropped(a_dropped),
    .SCLK(a_sclk), .SYNC(a_sync), .SDATA(a_sdata)
  );

  da2_multi_serializer #(
    .CHANNELS(1), .DATA_W(8), .CLK_DIV(1)
  ) u_b (
    .clk(clk), .rst(rst), .update(b_update),
    .value(b_value), .mode(b_mode),
    .busy(b_busy), .done(b_done), .dropped(b_dropped),
    .SCLK(b_sclk), .SYNC(b_sync), .SDATA(b_sdata)
  );

  initial begin
    for (int i = 0; i < 7; i++) begin
      a_cnt[i] = 0;
      b_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    a_cyc++;
    if (a_psclk && !a_sclk && !a_sync) begin
      a_cnt[C_FALL]++;
      a_bits0 = {a_bits0[14:0], a_sdata[0]};
      a_bits1 = {a_bits1[14:0], a_sdata[1]};
    end
    if (!a_sync && !a_sclk) a_cnt[C_SLOW]++;
    if (!a_sync) a_cnt[C_SYNC]++;
    if (!a_sync && a_psync) a_sync_start = a_cyc;
    if (a_busy) a_cnt[C_BUSY]++;
    if (!a_busy && a_pbusy) a_cnt[C_BFALL]++;
    if (a_done) begin
      a_cnt[C_DONE]++;
      a_done_cyc = a_cyc;
    end
    if (a_dropped) a_cnt[C_DROP]++;
    a_psclk = a_sclk;
    a_psync = a_sync;
    a_pbusy = a_busy;
  end

  always @(negedge clk) begin
    if (b_psclk && !b_sclk && !b_sync) begin
      b_cnt[C_FALL]++;
      b_bits = {b_bits[14:0], b_sdata[0]};
    end
    if (!b_sync && !b_sclk) b_cnt[C_SLOW]++;
    if (!b_sync) b_cnt[C_SYNC]++;
    if (b_busy) b_cnt[C_BUSY]++;
    if (!b_busy && b_pbusy) b_cnt[C_BFALL]++;
    if (b_done) b_cnt[C_DONE]++;
    if (b_dropped) b_cnt[C_DROP]++;
    b_psclk = b_sclk;
    b_psync = b_sync;
    b_pbusy = b_busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic int da(input int i);
    return a_cnt[i] - a_base[i];
  endfunction

  function automatic int db(input int i);
    return b_cnt[i] - b_base[i];
  endfunction

  // Called at posedge+1; update is sampled on the next posedge.
  task automatic pulse_a(input logic [23:0] v, input logic [3:0] m);
    a_base   = a_cnt;
    a_value  = v;
    a_mode   = m;
    a_update = 1'b1;
    @(posedge clk); #1;
    a_update = 1'b0;
  endtask

  task automatic upd_a(input logic [23:0] v, input logic [3:0] m);
    a_value  = v;
    a_mode   = m;
    a_update = 1'b1;
    @(posedge clk); #1;
    a_update = 1'b0;
  endtask

  task automatic pulse_b(input logic [7:0] v, input logic [1:0] m);
    b_base   = b_cnt;
    b_value  = v;
    b_mode   = m;
    b_update = 1'b1;
    @(posedge clk); #1;
    b_update = 1'b0;
  endtask

  // Returns at posedge+1 of the first cycle with busy low.
  task automatic wait_a(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!a_busy) break;
    end
    chk({tag, ".idle"}, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_b(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!b_busy) break;
    end
    chk({tag, ".idle"}, 32'(b_busy), 32'd0);
  endtask

  task automatic frame_a(input string tag, input logic [15:0] e0,
                         input logic [15:0] e1);
    chk({tag, ".ch0"},  32'(a_bits0), 32'(e0));
    chk({tag, ".ch1"},  32'(a_bits1), 32'(e1));
    chk({tag, ".sync"}, da(C_SYNC), 64);
    chk({tag, ".busy"}, da(C_BUSY), 66);
    chk({tag, ".done"}, da(C_DONE), 1);
    chk({tag, ".fall"}, da(C_FALL), 16);
    chk({tag, ".slow"}, da(C_SLOW), 32);
  endtask

  task automatic frame_b(input string tag, input logic [15:0] e);
    chk({tag, ".bits"}, 32'(b_bits), 32'(e));
    chk({tag, ".sync"}, db(C_SYNC), 32);
    chk({tag, ".busy"}, db(C_BUSY), 33);
    chk({tag, ".done"}, db(C_DONE), 1);
    chk({tag, ".fall"}, db(C_FALL), 16);
    chk({tag, ".slow"}, db(C_SLOW), 16);
  endtask

  initial begin
    bv[0] = 8'hA5; bm[0] = 2'b01; bf[0] = 16'h1A50;
    bv[1] = 8'hFF; bm[1] = 2'b11; bf[1] = 16'h3FF0;
    bv[2] = 8'h01; bm[2] = 2'b00; bf[2] = 16'h0010;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.sclk",  32'(a_sclk),    32'd1);
    chk("rst.sync",  32'(a_sync),    32'd1);
    chk("rst.sdata", 32'(a_sdata),   32'd0);
    chk("rst.busy",  32'(a_busy),    32'd0);
    chk("rst.done",  32'(a_done),    32'd0);
    chk("rst.drop",  32'(a_dropped), 32'd0);
    chk("rst.b_sync", 32'(b_sync),   32'd1);

    // Single frame on A.
    pulse_a({12'h123, 12'hABC}, {2'b11, 2'b00});
    wait_a("f1", 200);
    frame_a("f1", 16'h0ABC, 16'h3123);
    chk("f1.drop", da(C_DROP), 0);

`ifdef DA2_PENDING_EN
    // Two updates queued mid-frame; newest is sent next.
    pulse_a({12'h000, 12'h000}, 4'b0000);
    repeat (10) @(posedge clk); #1;
    upd_a({12'h111, 12'h111}, 4'b0000);
    repeat (10) @(posedge clk); #1;
    upd_a({12'h222, 12'h222}, 4'b0000);
    wait_a("pend", 400);
    chk("pend.ch0",  32'(a_bits0), 32'h0222);
    chk("pend.ch1",  32'(a_bits1), 32'h0222);
    chk("pend.busy", da(C_BUSY), 132);
    chk("pend.done", da(C_DONE), 2);
    chk("pend.fall", da(C_FALL), 32);
    chk("pend.drop", da(C_DROP), 1);
    chk("pend.bfall", da(C_BFALL), 1);
    chk("pend.gap", a_sync_start - a_done_cyc, 1);
`else
    // Update mid-frame is dropped and changes nothing.
    pulse_a({12'h456, 12'h789}, {2'b01, 2'b10});
    repeat (20) @(posedge clk); #1;
    upd_a({12'hFFF, 12'hFFF}, 4'b1111);
    wait_a("mid", 200);
    frame_a("mid", 16'h2789, 16'h1456);
    chk("mid.drop", da(C_DROP), 1);
    repeat (10) @(posedge clk); #1;
    chk("mid.no2nd", da(C_BUSY), 66);
`endif

    // Reset during bit 7.
    pulse_a({12'hFFF, 12'hFFF}, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      if (da(C_FALL) >= 7) break;
      @(posedge clk); #1;
    end
    chk("rmid.fall", da(C_FALL), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmid.sync", 32'(a_sync),  32'd1);
    chk("rmid.sclk", 32'(a_sclk),  32'd1);
    chk("rmid.busy", 32'(a_busy),  32'd0);
    chk("rmid.sdat", 32'(a_sdata), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("rmid.done", da(C_DONE), 0);
    pulse_a({12'h5A5, 12'h0F0}, {2'b10, 2'b01});
    wait_a("f2", 200);
    frame_a("f2", 16'h10F0, 16'h25A5);

`ifndef DA2_PENDING_EN
    // Update coinciding with done is lost.
    pulse_b(8'h3C, 2'b10);
    for (int i = 0; i < 60; i++) begin
      if (b_done) break;
      @(posedge clk); #1;
    end
    chk("dn.seen", 32'(b_done), 32'd1);
    b_update = 1'b1;
    @(posedge clk); #1;
    b_update = 1'b0;
    chk("dn.drop", 32'(b_dropped), 32'd1);
    chk("dn.busy", 32'(b_busy), 32'd0);
    frame_b("dn", 16'h23C0);
    @(posedge clk); #1;
    chk("dn.busy2", 32'(b_busy), 32'd0);
    chk("dn.drop2", 32'(b_dropped), 32'd0);
`endif

    // CLK_DIV=1, DATA_W=8, back-to-back frames.
    for (int i = 0; i < 3; i++) begin
      pulse_b(bv[i], bm[i]);
      wait_b($sformatf("b2b%0d", i), 100);
      frame_b($sformatf("b2b%0d", i), bf[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/da2_multi_serializer.md
Name: da2_multi_serializer

Overview:
- Parametrised N-channel serial DAC driver for DAC121S101-class converters (PmodDA2 style), with the SCLK divider built in.
- One shared SCLK/SYNC pair, one SDATA line per channel, and a 16-bit frame per channel: {2'b00, mode[1:0], data[11:0]}, MSB first.
- Adds a busy/done handshake, a per-channel power-down mode, configurable data width, overrun reporting, and an optional one-deep pending buffer.
- Sits between the filter datapath outputs and the Pmod pins.

Parameters:
- CHANNELS, 2, number of DAC channels / SDATA lines (1..8).
- DATA_W, 12, sample width per channel (1..12). Samples are MSB-aligned into 12 bits; unused LSBs are zero.
- CLK_DIV, 25, clk cycles per SCLK half-period (>=1). SCLK = f_clk/(2*CLK_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- update  in  1  single-cycle request to start a frame with current value/mode
- value  in  CHANNELS*DATA_W  packed samples; channel k at [k*DATA_W +: DATA_W]
- mode  in  CHANNELS*2  per-channel mode; 00 normal, 01 1k pulldown, 10 100k pulldown, 11 high-Z
- busy  out  1  frame in progress; update is not accepted when high
- done  out  1  one-cycle pulse on the last busy cycle of each frame
- dropped  out  1  one-cycle pulse when an update is lost
- SCLK  out  1  serial clock, idles high
- SYNC  out  1  frame sync, active low
- SDATA  out  CHANNELS  serial data, bit k drives channel k

Behaviour:
- Reset values: SCLK=1, SYNC=1, SDATA=0, busy=0, done=0, dropped=0; FSM in IDLE; divider and bit counters at 0; pending slot cleared.
- FSM states: IDLE -> SHIFT -> HOLD -> IDLE (or -> SHIFT with pending).
- IDLE, update=1:
  - At that clock edge, per-channel 16-bit shift registers are loaded with {2'b00, mode_k, value_k, zero pad}.
  - Also at that edge: busy=1, SYNC=0, SDATA=bit15 of each frame, SCLK=1; FSM -> SHIFT.
- SHIFT timing, D = CLK_DIV:
  - Each bit period is 2D cycles: SCLK high for D cycles, then low for D cycles.
  - SDATA changes only at bit-period boundaries (SCLK rising), so data is stable across the falling edge where the DAC samples.
  - The 4-bit counter counts 16 bit periods; SYNC stays low for exactly 32D cycles.
- Exit from SHIFT: after the 16th period, SYNC=1, SCLK=1, SDATA=0; FSM -> HOLD.
- HOLD: lasts D cycles (SYNC-high minimum). done=1 on the final HOLD cycle; busy falls the next cycle.
- Total busy time: exactly 33D cycles per frame.
- Update while busy, or in the same cycle as done: not accepted; dropped pulses one cycle later (baseline, see Optional Feature).
- Simultaneous rst and update: rst wins.
- Reset mid-frame: outputs return to reset values on the next cycle. The partial frame is aborted (SYNC high before the 16th edge, so the DAC discards it). No done pulse.
- Inputs value and mode are sampled only at load; changes during a frame have no effect.

Optional Feature:
- Macro: DA2_PENDING_EN.
- Defined:
  - Update while busy captures value/mode into a one-deep pending register.
  - Leaving HOLD with pending valid: the next cycle loads the frame straight into SHIFT; busy stays high continuously; done still pulses once per frame.
  - Update while pending is already valid overwrites the pending register (newest wins) and pulses dropped.
  - Reset clears pending.
- Undefined: there is no pending register; every update while busy pulses dropped; a new frame requires an update while busy=0.

Test Plan:
- Single frame, CHANNELS=2, CLK_DIV=2, value={12'h123,12'hABC}, mode={2'b11,2'b00}, update pulse:
  - SDATA[0] sampled on SCLK falls = 0000_1010_1011_1100.
  - SDATA[1] = 0011_0001_0010_0011.
  - SYNC low 64 cycles, busy 66 cycles, one done pulse, 16 SCLK falling edges.
- DATA_W=8, value 8'hA5, mode 01: frame bits = 0001_1010_0101_0000.
- Update pulsed mid-frame, macro off: dropped pulses once; frame unchanged; no second frame; busy drops after 33D cycles.
- Macro on, two updates mid-frame (0x111, then 0x222):
  - dropped pulses once on the second update.
  - The second frame carries 0x222 and starts one cycle after the first done.
  - busy never deasserts between frames.
- rst asserted at bit 7 of a frame: SYNC=1, SCLK=1, busy=0 the next cycle, no done. A fresh update afterwards sends a complete, correct frame.
- CLK_DIV=1 stress, back-to-back updates issued the cycle after busy falls: each frame is 33 busy cycles with SCLK period 2 cycles and bit patterns correct.
